// File: rtl/divisor_pkg.sv
// divisor_pkg: shared FSM states, counter width and sign helpers for the sequential divider
// Ports: none (package). DIV_WIDTH is the default operand width used by the helpers.
package divisor_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int CNT_W = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, ZERO, FIX} state_t;

    function automatic logic [DIV_WIDTH-1:0] negate(input logic [DIV_WIDTH-1:0] x);
        return ~x + 1'b1;
    endfunction

    // -2^31 maps to itself, which is the correct magnitude once read as unsigned
    function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] x);
        return x[DIV_WIDTH-1] ? negate(x) : x;
    endfunction
endpackage

// File: rtl/divisor_step.sv
// divisor_step: one combinational restoring-division iteration (shift, compare, subtract)
// Ports: r/q partial remainder and quotient in, d divisor magnitude, r_next/q_next after one step.
module divisor_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_next,
    output logic [WIDTH-1:0] q_next
);
    logic [WIDTH:0] sh;
    logic           ge;

    // a set top bit of r means the shifted value exceeds any divisor
    always_comb begin
        sh     = {r[WIDTH-1:0], q[WIDTH-1]};
        ge     = r[WIDTH] | (sh >= {1'b0, d});
        r_next = ge ? sh - {1'b0, d} : sh;
        q_next = {q[WIDTH-2:0], ge};
    end
endmodule

// File: rtl/divisor.sv
// divisor: sequential 32-bit restoring divider, quotient to div_lo, remainder to div_hi
// Ports: clk, reset (async active-high), div_start, dividend, divisor_in,
//        div_signed (only with DIVISOR_UNSIGNED_EN), div_busy, div_done, div_zero, div_hi, div_lo.
// Build option: define DIVISOR_UNSIGNED_EN to add div_signed (0 = unsigned DIVU); otherwise always signed.
module divisor
    import divisor_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor_in,
`ifdef DIVISOR_UNSIGNED_EN
    input  logic             div_signed,
`endif
    output logic             div_busy,
    output logic             div_done,
    output logic             div_zero,
    output logic [WIDTH-1:0] div_hi,
    output logic [WIDTH-1:0] div_lo
);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   r, r_next;
    logic [WIDTH-1:0] q, q_next, d;
    logic             neg_q, neg_r;
    logic             sgn;

`ifdef DIVISOR_UNSIGNED_EN
    assign sgn = div_signed;
`else
    assign sgn = 1'b1;
`endif

    divisor_step #(.WIDTH(WIDTH)) u_step (
        .r      (r),
        .q      (q),
        .d      (d),
        .r_next (r_next),
        .q_next (q_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            r        <= '0;
            q        <= '0;
            d        <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_busy <= 1'b0;
            div_done <= 1'b0;
            div_zero <= 1'b0;
            div_hi   <= '0;
            div_lo   <= '0;
        end else begin
            div_done <= 1'b0;
            case (state)
                IDLE: if (div_start) begin
                    q        <= sgn ? abs_val(dividend) : dividend;
                    d        <= sgn ? abs_val(divisor_in) : divisor_in;
                    neg_q    <= sgn & (dividend[WIDTH-1] ^ divisor_in[WIDTH-1]);
                    neg_r    <= sgn & dividend[WIDTH-1];
                    r        <= '0;
                    cnt      <= '0;
                    div_busy <= 1'b1;
                    div_zero <= 1'b0;
                    state    <= (divisor_in == '0) ? ZERO : RUN;
                end
                RUN: begin
                    r     <= r_next;
                    q     <= q_next;
                    cnt   <= cnt + 1'b1;
                    state <= (cnt == CNT_W'(WIDTH - 1)) ? FIX : RUN;
                end
                ZERO: begin
                    div_zero <= 1'b1;
                    div_done <= 1'b1;
                    div_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    div_lo   <= neg_q ? negate(q) : q;
                    div_hi   <= neg_r ? negate(r[WIDTH-1:0]) : r[WIDTH-1:0];
                    div_done <= 1'b1;
                    div_busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_divisor.sv
// tb_divisor: scoreboard bench for divisor with directed vectors
module tb_divisor;
    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        zero;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        div_start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor_in = '0;
    logic        div_signed = 1'b1;
    logic        div_busy, div_done, div_zero;
    logic [31:0] div_hi, div_lo;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    divisor dut (
        .clk        (clk),
        .reset      (reset),
        .div_start  (div_start),
        .dividend   (dividend),
        .divisor_in (divisor_in),
`ifdef DIVISOR_UNSIGNED_EN
        .div_signed (div_signed),
`endif
        .div_busy   (div_busy),
        .div_done   (div_done),
        .div_zero   (div_zero),
        .div_hi     (div_hi),
        .div_lo     (div_lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && div_done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done at cycle %0d want none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("lo", div_lo, e.lo);
                check("hi", div_hi, e.hi);
                check("zero", {31'b0, div_zero}, {31'b0, e.zero});
                check("done_cycle", cyc, e.cyc);
                check("busy_at_done", {31'b0, div_busy}, 32'd0);
            end
        end
    end

    // issue one start; expected done edge = accept edge + lat
    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] lo,
                       input logic [31:0] hi, input logic z, input int lat, input logic sg);
        div_start  = 1'b1;
        dividend   = a;
        divisor_in = b;
        div_signed = sg;
        sb.push_back('{lo, hi, z, cyc + 1 + lat});
        @(negedge clk);
        div_start  = 1'b0;
        dividend   = $urandom;
        divisor_in = $urandom;
        div_signed = ~sg;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d pending results want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, div_busy}, 32'd0);
        check("rst_done", {31'b0, div_done}, 32'd0);
        check("rst_lo", div_lo, 32'd0);
        check("rst_hi", div_hi, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        run(32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33, 1'b1);
        wait_idle();
        run(32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0, 33, 1'b1);
        wait_idle();
        run(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 1'b1);
        wait_idle();
        run(32'd7, 32'd0, 32'd14, 32'd2, 1'b1, 1, 1'b1);
        wait_idle();
        run(32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 1'b0, 33, 1'b1);
        wait_idle();
        run(32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 33, 1'b1);
        wait_idle();
        run(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 33, 1'b1);
        repeat (3) @(negedge clk);
        check("busy_mid_run", {31'b0, div_busy}, 32'd1);
        div_start  = 1'b1;
        dividend   = 32'd9;
        divisor_in = 32'd0;
        @(negedge clk);
        div_start  = 1'b0;
        wait_idle();
        @(negedge clk);
        run(32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 33, 1'b1);
        void'(sb.pop_back());
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", {31'b0, div_busy}, 32'd0);
        check("abort_lo", div_lo, 32'd0);
        check("abort_hi", div_hi, 32'd0);
        check("abort_zero", {31'b0, div_zero}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        run(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33, 1'b1);
        wait_idle();
`ifdef DIVISOR_UNSIGNED_EN
        run(32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'd1, 1'b0, 33, 1'b0);
        wait_idle();
        run(32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFF, 1'b0, 33, 1'b1);
        wait_idle();
`endif
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
